// File: rtl/rv_pkg.sv
// Shared definitions for the integer writeback path: data width, register
// address width and the request record carried through the writeback buffer.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline and long-latency sources, register-file
// write port and decode bypass. Arbiter uses 'slave', its environment 'master'.
interface wb_arbiter_if #(
  parameter int XLEN = 32
);

  localparam int AW = rv_pkg::REG_ADDR_W;

  logic            p_valid;
  logic [AW-1:0]   p_rd;
  logic [XLEN-1:0] p_data;
  logic            l_valid;
  logic            l_ready;
  logic [AW-1:0]   l_rd;
  logic [XLEN-1:0] l_data;
  logic            stall_req;
  logic            rf_en;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_data;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            fwd_a_hit;
  logic            fwd_b_hit;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic            err;

  modport slave (
    input  p_valid, p_rd, p_data, l_valid, l_rd, l_data, rs1, rs2,
    output l_ready, stall_req, rf_en, rf_rd, rf_data,
           fwd_a_hit, fwd_b_hit, fwd_a, fwd_b, err
  );

  modport master (
    output p_valid, p_rd, p_data, l_valid, l_rd, l_data, rs1, rs2,
    input  l_ready, stall_req, rf_en, rf_rd, rf_data,
           fwd_a_hit, fwd_b_hit, fwd_a, fwd_b, err
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests. Head is read straight from
// storage; a push into an empty FIFO is not visible until the next cycle.
module wb_fifo
  import rv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  wb_req_t          wr_req,
  output wb_req_t          rd_req,
  output logic [CNT_W-1:0] count
);

  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = push && (count_q != CNT_W'(DEPTH));
    pop_ok   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Explicit wrap keeps DEPTH=1 (single-bit pointer, one slot) correct.
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_req;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_req = mem_q[rd_ptr_q];
  assign count  = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: merges the non-stallable pipeline with a
// buffered long-latency source, forces a stall when the buffer head starves.
module wb_arbiter
  import rv_pkg::*;
#(
  parameter int XLEN         = rv_pkg::XLEN,
  parameter int LBUF_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  wb_arbiter_if.slave       bus
);

  localparam int CNT_W = $clog2(LBUF_DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  wb_req_t          head;
  wb_req_t          l_req;
  logic [CNT_W-1:0] count;
  logic             buf_empty;
  logic             l_ready;
  logic             l_fire;
  logic             sel_buf, sel_pipe, sel_dir;
  logic             push, pop;

  logic                  rf_en_q, rf_en_d;
  logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]       rf_data_q, rf_data_d;
  logic                  stall_q, stall_d;
  logic                  err_q, err_d;
  logic [ST_W-1:0]       starve_q, starve_d;

  assign l_req = '{rd: bus.l_rd, data: bus.l_data};

  wb_fifo #(
    .DEPTH (LBUF_DEPTH)
  ) u_lbuf (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wr_req (l_req),
    .rd_req (head),
    .count  (count)
  );

  always_comb begin
    buf_empty = (count == '0);
    // Based on the current count only: a pop this cycle does not open a slot.
    l_ready   = !rst && (count < CNT_W'(LBUF_DEPTH));
    l_fire    = bus.l_valid && l_ready;

    sel_buf  = 1'b0;
    sel_pipe = 1'b0;
    sel_dir  = 1'b0;
    if (stall_q)                                  sel_buf  = !buf_empty;
    else if (bus.p_valid && bus.p_rd != '0)       sel_pipe = 1'b1;
    else if (!buf_empty)                          sel_buf  = 1'b1;
    else if (l_fire && bus.l_rd != '0)            sel_dir  = 1'b1;

    // x0 handshakes complete here and are simply never pushed.
    push = l_fire && !sel_dir && (bus.l_rd != '0);
    pop  = sel_buf;

    rf_en_d   = sel_buf || sel_pipe || sel_dir;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (sel_buf) begin
      rf_rd_d   = head.rd;
      rf_data_d = head.data;
    end else if (sel_pipe) begin
      rf_rd_d   = bus.p_rd;
      rf_data_d = bus.p_data;
    end else if (sel_dir) begin
      rf_rd_d   = bus.l_rd;
      rf_data_d = bus.l_data;
    end

    stall_d  = 1'b0;
    starve_d = starve_q;
    if (buf_empty || pop) begin
      starve_d = '0;
    end else if (starve_q + ST_W'(1) == ST_W'(STARVE_LIMIT)) begin
      stall_d  = 1'b1;
      starve_d = '0;
    end else begin
      starve_d = starve_q + ST_W'(1);
    end

    err_d = err_q || (bus.p_valid && stall_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_en_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      stall_q   <= 1'b0;
      err_q     <= 1'b0;
      starve_q  <= '0;
    end else begin
      rf_en_q   <= rf_en_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      stall_q   <= stall_d;
      err_q     <= err_d;
      starve_q  <= starve_d;
    end
  end

  assign bus.l_ready   = l_ready;
  assign bus.stall_req = stall_q;
  assign bus.rf_en     = rf_en_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_data   = rf_data_q;
  assign bus.err       = err_q;
  assign bus.fwd_a_hit = rf_en_q && (rf_rd_q == bus.rs1) && (bus.rs1 != '0);
  assign bus.fwd_b_hit = rf_en_q && (rf_rd_q == bus.rs2) && (bus.rs2 != '0);
  assign bus.fwd_a     = rf_data_q;
  assign bus.fwd_b     = rf_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: one task per scenario with hand-derived
// expectations for write-port selection, starvation, x0, full buffer, reset.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.XLEN(32)) bus ();

  wb_arbiter #(
    .XLEN         (32),
    .LBUF_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.p_valid = 1'b0; bus.p_rd = '0; bus.p_data = '0;
    bus.l_valid = 1'b0; bus.l_rd = '0; bus.l_data = '0;
    bus.rs1 = '0; bus.rs2 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick(); tick();
    checks++; if (bus.rf_en !== 1'b0) $display("FAIL reset_rf_en got %0b want 0", bus.rf_en); else passed++;
    checks++; if (bus.rf_rd !== 5'd0) $display("FAIL reset_rf_rd got %0d want 0", bus.rf_rd); else passed++;
    checks++; if (bus.rf_data !== 32'h0) $display("FAIL reset_rf_data got %h want 0", bus.rf_data); else passed++;
    checks++; if (bus.stall_req !== 1'b0) $display("FAIL reset_stall got %0b want 0", bus.stall_req); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL reset_err got %0b want 0", bus.err); else passed++;
    checks++; if (bus.l_ready !== 1'b0) $display("FAIL reset_l_ready_in_rst got %0b want 0", bus.l_ready); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (bus.l_ready !== 1'b1) $display("FAIL reset_l_ready_after got %0b want 1", bus.l_ready); else passed++;
  endtask

  task automatic test_pipeline();
    bus.p_valid = 1'b1; bus.p_rd = 5'd5; bus.p_data = 32'h1234;
    tick();
    bus.p_valid = 1'b0; bus.rs1 = 5'd5; bus.rs2 = 5'd6;
    #1;
    checks++; if (bus.rf_en !== 1'b1) $display("FAIL pipe_rf_en got %0b want 1", bus.rf_en); else passed++;
    checks++; if (bus.rf_rd !== 5'd5) $display("FAIL pipe_rf_rd got %0d want 5", bus.rf_rd); else passed++;
    checks++; if (bus.rf_data !== 32'h1234) $display("FAIL pipe_rf_data got %h want 1234", bus.rf_data); else passed++;
    checks++; if (bus.fwd_a_hit !== 1'b1) $display("FAIL pipe_fwd_a_hit got %0b want 1", bus.fwd_a_hit); else passed++;
    checks++; if (bus.fwd_a !== 32'h1234) $display("FAIL pipe_fwd_a got %h want 1234", bus.fwd_a); else passed++;
    checks++; if (bus.fwd_b_hit !== 1'b0) $display("FAIL pipe_fwd_b_miss got %0b want 0", bus.fwd_b_hit); else passed++;
    bus.rs2 = 5'd5;
    #1;
    checks++; if (bus.fwd_b_hit !== 1'b1) $display("FAIL pipe_fwd_b_hit got %0b want 1", bus.fwd_b_hit); else passed++;
    tick();
    checks++; if (bus.rf_en !== 1'b0) $display("FAIL pipe_idle_rf_en got %0b want 0", bus.rf_en); else passed++;
    checks++; if (bus.rf_rd !== 5'd5) $display("FAIL pipe_hold_rf_rd got %0d want 5", bus.rf_rd); else passed++;
    checks++; if (bus.fwd_a_hit !== 1'b0) $display("FAIL pipe_fwd_after got %0b want 0", bus.fwd_a_hit); else passed++;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
  endtask

  task automatic test_direct();
    bus.l_valid = 1'b1; bus.l_rd = 5'd7; bus.l_data = 32'hAA;
    #1;
    checks++; if (bus.l_ready !== 1'b1) $display("FAIL direct_l_ready got %0b want 1", bus.l_ready); else passed++;
    tick();
    bus.l_valid = 1'b0;
    checks++; if (bus.rf_en !== 1'b1) $display("FAIL direct_rf_en got %0b want 1", bus.rf_en); else passed++;
    checks++; if (bus.rf_rd !== 5'd7) $display("FAIL direct_rf_rd got %0d want 7", bus.rf_rd); else passed++;
    checks++; if (bus.rf_data !== 32'hAA) $display("FAIL direct_rf_data got %h want aa", bus.rf_data); else passed++;
    tick();
    checks++; if (bus.rf_en !== 1'b0) $display("FAIL direct_not_buffered got %0b want 0", bus.rf_en); else passed++;
  endtask

  task automatic test_collision();
    bus.p_valid = 1'b1; bus.p_rd = 5'd3; bus.p_data = 32'h33;
    bus.l_valid = 1'b1; bus.l_rd = 5'd4; bus.l_data = 32'h44;
    tick();
    idle();
    checks++; if (bus.rf_rd !== 5'd3 || bus.rf_en !== 1'b1) $display("FAIL coll_first got en=%0b rd=%0d want en=1 rd=3", bus.rf_en, bus.rf_rd); else passed++;
    tick();
    checks++; if (bus.rf_rd !== 5'd4 || bus.rf_en !== 1'b1) $display("FAIL coll_second got en=%0b rd=%0d want en=1 rd=4", bus.rf_en, bus.rf_rd); else passed++;
    checks++; if (bus.rf_data !== 32'h44) $display("FAIL coll_second_data got %h want 44", bus.rf_data); else passed++;
    tick();
    checks++; if (bus.rf_en !== 1'b0) $display("FAIL coll_drain got %0b want 0", bus.rf_en); else passed++;
  endtask

  // Buffer one entry behind a busy pipeline, then keep the pipeline busy.
  task automatic starve_setup(input logic [4:0] lrd, input logic [31:0] ldat);
    logic [4:0] exp_rd;
    bus.p_valid = 1'b1; bus.p_rd = 5'd1; bus.p_data = 32'h100;
    bus.l_valid = 1'b1; bus.l_rd = lrd; bus.l_data = ldat;
    tick();
    bus.l_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_rd = 5'(2 + i);
      bus.p_valid = 1'b1; bus.p_rd = exp_rd; bus.p_data = 32'(i);
      tick();
      checks++; if (bus.stall_req !== (i == 3)) $display("FAIL starve_stall_c%0d got %0b want %0b", i, bus.stall_req, (i == 3)); else passed++;
      checks++; if (bus.rf_rd !== exp_rd) $display("FAIL starve_pipe_rd_c%0d got %0d want %0d", i, bus.rf_rd, exp_rd); else passed++;
    end
  endtask

  task automatic test_starvation();
    starve_setup(5'd9, 32'h99);
    bus.p_valid = 1'b0;
    tick();
    checks++; if (bus.rf_en !== 1'b1 || bus.rf_rd !== 5'd9) $display("FAIL starve_head got en=%0b rd=%0d want en=1 rd=9", bus.rf_en, bus.rf_rd); else passed++;
    checks++; if (bus.rf_data !== 32'h99) $display("FAIL starve_head_data got %h want 99", bus.rf_data); else passed++;
    checks++; if (bus.stall_req !== 1'b0) $display("FAIL starve_pulse_len got %0b want 0", bus.stall_req); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL starve_err_clean got %0b want 0", bus.err); else passed++;
    tick();
    checks++; if (bus.rf_en !== 1'b0) $display("FAIL starve_drain got %0b want 0", bus.rf_en); else passed++;
  endtask

  task automatic test_violation();
    starve_setup(5'd10, 32'hA0);
    bus.p_valid = 1'b1; bus.p_rd = 5'd11; bus.p_data = 32'hBB;
    tick();
    bus.p_valid = 1'b0;
    checks++; if (bus.rf_rd !== 5'd10 || bus.rf_data !== 32'hA0) $display("FAIL viol_head got rd=%0d data=%h want rd=10 data=a0", bus.rf_rd, bus.rf_data); else passed++;
    checks++; if (bus.err !== 1'b1) $display("FAIL viol_err got %0b want 1", bus.err); else passed++;
    tick();
    checks++; if (bus.rf_en !== 1'b0) $display("FAIL viol_dropped got en=%0b rd=%0d want en=0", bus.rf_en, bus.rf_rd); else passed++;
    checks++; if (bus.err !== 1'b1) $display("FAIL viol_sticky got %0b want 1", bus.err); else passed++;
  endtask

  task automatic test_x0_full();
    bus.p_valid = 1'b1; bus.p_rd = 5'd0; bus.p_data = 32'hDEAD;
    tick();
    checks++; if (bus.rf_en !== 1'b0) $display("FAIL x0_pipe got %0b want 0", bus.rf_en); else passed++;
    bus.p_valid = 1'b0;
    bus.l_valid = 1'b1; bus.l_rd = 5'd0; bus.l_data = 32'hBEEF;
    #1;
    checks++; if (bus.l_ready !== 1'b1) $display("FAIL x0_l_ready got %0b want 1", bus.l_ready); else passed++;
    tick();
    bus.l_valid = 1'b0;
    checks++; if (bus.rf_en !== 1'b0) $display("FAIL x0_direct got %0b want 0", bus.rf_en); else passed++;
    tick();
    checks++; if (bus.rf_en !== 1'b0) $display("FAIL x0_not_buffered got %0b want 0", bus.rf_en); else passed++;

    bus.p_valid = 1'b1; bus.p_rd = 5'd12; bus.p_data = 32'hC12;
    bus.l_valid = 1'b1; bus.l_rd = 5'd13; bus.l_data = 32'hD1;
    tick();
    checks++; if (bus.rf_rd !== 5'd12) $display("FAIL full_p12 got %0d want 12", bus.rf_rd); else passed++;
    bus.p_rd = 5'd14; bus.l_rd = 5'd15; bus.l_data = 32'hD2;
    #1;
    checks++; if (bus.l_ready !== 1'b1) $display("FAIL full_one_entry_ready got %0b want 1", bus.l_ready); else passed++;
    tick();
    checks++; if (bus.rf_rd !== 5'd14) $display("FAIL full_p14 got %0d want 14", bus.rf_rd); else passed++;
    bus.p_rd = 5'd16; bus.l_rd = 5'd17; bus.l_data = 32'hD3;
    #1;
    checks++; if (bus.l_ready !== 1'b0) $display("FAIL full_not_ready got %0b want 0", bus.l_ready); else passed++;
    tick();
    checks++; if (bus.rf_rd !== 5'd16) $display("FAIL full_p16 got %0d want 16", bus.rf_rd); else passed++;
    bus.p_valid = 1'b0;
    #1;
    checks++; if (bus.l_ready !== 1'b0) $display("FAIL full_pop_no_ready got %0b want 0", bus.l_ready); else passed++;
    tick();
    checks++; if (bus.rf_rd !== 5'd13 || bus.rf_data !== 32'hD1) $display("FAIL full_head13 got rd=%0d data=%h want rd=13 data=d1", bus.rf_rd, bus.rf_data); else passed++;
    checks++; if (bus.l_ready !== 1'b1) $display("FAIL full_ready_after_pop got %0b want 1", bus.l_ready); else passed++;
    tick();
    bus.l_valid = 1'b0;
    checks++; if (bus.rf_rd !== 5'd15 || bus.rf_data !== 32'hD2) $display("FAIL full_head15 got rd=%0d data=%h want rd=15 data=d2", bus.rf_rd, bus.rf_data); else passed++;
    tick();
    checks++; if (bus.rf_rd !== 5'd17 || bus.rf_data !== 32'hD3) $display("FAIL full_head17 got rd=%0d data=%h want rd=17 data=d3", bus.rf_rd, bus.rf_data); else passed++;
    tick();
    checks++; if (bus.rf_en !== 1'b0) $display("FAIL full_drain got %0b want 0", bus.rf_en); else passed++;
  endtask

  task automatic test_reset_mid();
    bus.p_valid = 1'b1; bus.p_rd = 5'd20; bus.p_data = 32'h20;
    bus.l_valid = 1'b1; bus.l_rd = 5'd21; bus.l_data = 32'h21;
    tick();
    bus.p_rd = 5'd22; bus.l_rd = 5'd23; bus.l_data = 32'h23;
    tick();
    rst = 1'b1;
    bus.p_valid = 1'b0; bus.l_rd = 5'd24; bus.l_data = 32'h24;
    #1;
    checks++; if (bus.l_ready !== 1'b0) $display("FAIL rstmid_l_ready got %0b want 0", bus.l_ready); else passed++;
    tick();
    checks++; if (bus.rf_en !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_data !== 32'h0) $display("FAIL rstmid_outputs got en=%0b rd=%0d data=%h want 0", bus.rf_en, bus.rf_rd, bus.rf_data); else passed++;
    checks++; if (bus.err !== 1'b0 || bus.stall_req !== 1'b0) $display("FAIL rstmid_err_stall got err=%0b stall=%0b want 0", bus.err, bus.stall_req); else passed++;
    rst = 1'b0;
    bus.l_valid = 1'b0;
    #1;
    checks++; if (bus.l_ready !== 1'b1) $display("FAIL rstmid_l_ready_after got %0b want 1", bus.l_ready); else passed++;
    tick();
    checks++; if (bus.rf_en !== 1'b0) $display("FAIL rstmid_no_write1 got %0b want 0", bus.rf_en); else passed++;
    tick();
    checks++; if (bus.rf_en !== 1'b0) $display("FAIL rstmid_no_write2 got %0b want 0", bus.rf_en); else passed++;
  endtask

  initial begin
    idle();
    test_reset();
    test_pipeline();
    test_direct();
    test_collision();
    test_starvation();
    test_violation();
    test_x0_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that drives the single write port of the integer register file. It merges results from the in-order pipeline, which cannot be back-pressured, with results from a long-latency unit (loads, mul/div) that uses a valid/ready handshake. Long-latency results wait in a small buffer until the write port is free. The block registers the write request for the register file and provides bypass data for that in-flight write to the decode-stage read operands.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `LBUF_DEPTH`, 2, long-latency buffer entries (≥1, power of 2).
- `STARVE_LIMIT`, 4, cycles a buffered head may wait before forcing a pipeline stall.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `p_valid` in 1: pipeline writeback request.
- `p_rd` in 5: pipeline destination register.
- `p_data` in XLEN: pipeline result.
- `l_valid` in 1: long-latency result valid.
- `l_ready` out 1: buffer can accept.
- `l_rd` in 5: long-latency destination.
- `l_data` in XLEN: long-latency result.
- `stall_req` out 1: pipeline must hold `p_valid` low this cycle.
- `rf_en` out 1: register-file write enable.
- `rf_rd` out 5: register-file write address.
- `rf_data` out XLEN: register-file write data.
- `rs1`, `rs2` in 5: decode read addresses.
- `fwd_a_hit`, `fwd_b_hit` out 1: bypass valid for rs1/rs2.
- `fwd_a`, `fwd_b` out XLEN: bypass data.
- `err` out 1: sticky protocol-violation flag.

## Operation
- Write-port selection each cycle, in priority order:
  1. Buffer head, if `stall_req`=1.
  2. Pipeline, if `p_valid` and `p_rd`≠0.
  3. Buffer head, if buffer non-empty.
  4. Direct long-latency path, if buffer empty and `l_valid`&&`l_ready` and `l_rd`≠0.
  5. Otherwise no write.
- The selected request loads `rf_en/rf_rd/rf_data` at the next edge. With no selection, `rf_en`←0 and `rf_rd/rf_data` hold their values.
- `x0` filtering:
  - `p_valid` with `p_rd`=0 is a no-op and does not block the buffer.
  - A long-latency handshake with `l_rd`=0 completes and is discarded.
- `l_ready` = `!rst && count < LBUF_DEPTH`, computed from the current count only, so a same-cycle pop does not raise it.
- A handshake not taken by the direct path pushes to the tail. Push and pop in the same cycle leave the count unchanged.
- Starvation counter:
  - Increments each cycle the buffer is non-empty and the head is not written.
  - Clears on every pop and when the buffer is empty.
  - When the counter reaches `STARVE_LIMIT`, `stall_req` is registered high for exactly one cycle. The counter clears in that same cycle.
- `p_valid`=1 while `stall_req`=1 is a violation: the request is dropped and `err` sets. `err` clears only on `rst`.
- Ordering across the two sources is not enforced. The upstream scoreboard guarantees no WAW between pipeline and long-latency writes in flight.
- Bypass:
  - `fwd_a_hit` = `rf_en && rf_rd==rs1 && rs1≠0`, and `fwd_a` = `rf_data`. B is identical using `rs2`.
  - Bypass is purely combinational from registered state and the rs inputs.
  - Buffered entries are not bypassed; the scoreboard stalls readers of those registers.

## Timing
- Reset values: `rf_en`=0, `rf_rd`=0, `rf_data`=0, `stall_req`=0, `err`=0, buffer empty, counter 0.
- `l_ready`=0 while `rst`=1 and becomes 1 in the first cycle after reset.
- Latency to `rf_en` high:
  - Pipeline: 1 cycle.
  - Direct long-latency path: 1 cycle.
  - Buffered result: ≥2 cycles.
- Worst-case buffered wait is `STARVE_LIMIT`+1 cycles from reaching the head.
- Full buffer: `l_ready`=0 and the upstream holds `l_valid/l_rd/l_data` stable.
- Reset mid-operation:
  - Buffer contents are discarded and outputs return to reset values at the next edge.
  - The handshake in the reset cycle is not accepted.
- Simultaneous `p_valid` (rd≠0) and `l_valid` with an empty buffer: the pipeline writes and the long-latency result is pushed.

## Structure
- Shared package `rv_pkg`:
  - `XLEN`, `REG_ADDR_W`=5.
  - Typedef `wb_req_t` {rd, data}.
- Sub-module `wb_fifo`: synchronous FIFO of `wb_req_t` with push/pop/count. It has no internal bypass.
- The arbiter, starvation counter and bypass logic stay in `wb_arbiter`.

## Test plan
- **Pipeline write:** `p_valid`=1, `p_rd`=5, `p_data`=0x1234 → next cycle `rf_en`=1, `rf_rd`=5, `rf_data`=0x1234. With `rs1`=5 in that cycle → `fwd_a_hit`=1, `fwd_a`=0x1234.
- **Direct path:** idle pipeline, `l_valid`=1, `l_rd`=7, `l_data`=0xAA → one cycle later `rf_rd`=7, `rf_data`=0xAA; count stays 0.
- **Collision:** `p_valid` (rd=3) and `l_valid` (rd=4) in the same cycle → rd 3 written at cycle+1, rd 4 at cycle+2.
- **Starvation:** continuous `p_valid` with 1 buffered entry → `stall_req` pulses after 4 cycles, the head is written the following cycle, and `err` stays 0. Asserting `p_valid` during the pulse sets `err`=1 and drops that write.
- **x0 and full buffer:** `p_rd`=0 writes never assert `rf_en`. Buffer full (2 entries) → `l_ready`=0 until a pop.
- **Reset mid-run:** `rst` with 2 buffered entries → all outputs at reset values, no further writes, `l_ready`=1 one cycle after reset deasserts.
